regfile_spill_fill: RTL and testbench

Sequencer that drives the port side of the 8×16-bit register file to move its full contents over streams. A spill reads R0..R7 in order and emits them on a valid/ready output stream. A fill accepts eight words from a valid/ready input stream and writes them into R0..R7. It sits beside the register file in the decode stage and serves context save/restore and debug dump; it owns read port 1 and the write port only while busy.

---
 rtl/regfile_spill_fill_pkg.sv | 24 ++
 rtl/regfile_spill_fill_if.sv | 38 +++
 rtl/regfile_beat_counter.sv | 35 +++
 rtl/regfile_spill_fill.sv | 160 ++++++++++++++++
 tb/tb_regfile_spill_fill.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/regfile_spill_fill_pkg.sv
// regfile_spill_fill_pkg
// Shared constants and types for the register file spill/fill sequencer.
// Optional feature macro: RF_SPILL_CHECKSUM_EN adds a ninth XOR checksum beat to each transfer.
package regfile_spill_fill_pkg;

    localparam int unsigned NUM_REGS   = 8;
    localparam int unsigned DATA_WIDTH = 16;
    localparam int unsigned SEL_WIDTH  = 3;

`ifdef RF_SPILL_CHECKSUM_EN
    localparam int unsigned BEAT_COUNT = NUM_REGS + 1;
`else
    localparam int unsigned BEAT_COUNT = NUM_REGS;
`endif

    localparam int unsigned BEAT_WIDTH = $clog2(BEAT_COUNT);

    typedef enum logic [1:0] {
        StIdle,
        StSpill,
        StFill
    } stateT;

endpackage

// File: rtl/regfile_spill_fill_if.sv
// regfile_spill_fill_if
// Groups the register file port and the two word streams used by the sequencer.
//   rf_read_sel/rf_read_data                 : register file read port 1 (combinational read)
//   rf_write_en/rf_write_sel/rf_write_data   : register file write port
//   out_valid/out_ready/out_data/out_last    : spill stream (sequencer is source)
//   in_valid/in_ready/in_data/in_last        : fill stream (sequencer is sink)
// master = sequencer side, slave = register file / stream peers.
interface regfile_spill_fill_if;

    logic [regfile_spill_fill_pkg::SEL_WIDTH-1:0]  rf_read_sel;
    logic [regfile_spill_fill_pkg::DATA_WIDTH-1:0] rf_read_data;
    logic                                          rf_write_en;
    logic [regfile_spill_fill_pkg::SEL_WIDTH-1:0]  rf_write_sel;
    logic [regfile_spill_fill_pkg::DATA_WIDTH-1:0] rf_write_data;

    logic                                          out_valid;
    logic                                          out_ready;
    logic [regfile_spill_fill_pkg::DATA_WIDTH-1:0] out_data;
    logic                                          out_last;

    logic                                          in_valid;
    logic                                          in_ready;
    logic [regfile_spill_fill_pkg::DATA_WIDTH-1:0] in_data;
    logic                                          in_last;

    modport master (
        output rf_read_sel, rf_write_en, rf_write_sel, rf_write_data,
        output out_valid, out_data, out_last, in_ready,
        input  rf_read_data, out_ready, in_valid, in_data, in_last
    );

    modport slave (
        input  rf_read_sel, rf_write_en, rf_write_sel, rf_write_data,
        input  out_valid, out_data, out_last, in_ready,
        output rf_read_data, out_ready, in_valid, in_data, in_last
    );

endinterface

// File: rtl/regfile_beat_counter.sv
// regfile_beat_counter
// Beat index for spill/fill transfers.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   clear    : restart at beat 0 (wins over incr)
//   incr     : advance one beat
//   idx      : current beat index
//   lastBeat : idx is the final beat of a transfer
module regfile_beat_counter
    import regfile_spill_fill_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    input  logic                  incr,
    output logic [BEAT_WIDTH-1:0] idx,
    output logic                  lastBeat
);

    logic [BEAT_WIDTH-1:0] idxQ;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idxQ <= '0;
        end else if (clear) begin
            idxQ <= '0;
        end else if (incr) begin
            idxQ <= idxQ + BEAT_WIDTH'(1);
        end
    end

    assign idx      = idxQ;
    assign lastBeat = (idxQ == BEAT_WIDTH'(BEAT_COUNT - 1));

endmodule

// File: rtl/regfile_spill_fill.sv
// regfile_spill_fill
// Moves the whole 8x16 register file out over a stream (spill) or in from a stream (fill).
//   clk       : clock, rising edge
//   rst       : asynchronous active-low reset
//   spill_req : start a spill (only looked at while idle; wins over fill_req)
//   fill_req  : start a fill (only looked at while idle)
//   busy      : spill or fill in progress
//   done      : one-cycle pulse after an operation ends
//   err       : sticky framing/checksum error, cleared when a new request is accepted
//   bus       : register file port plus spill/fill streams (master side)
// Optional feature macro: RF_SPILL_CHECKSUM_EN (ninth beat carries XOR of R0..R7).
module regfile_spill_fill
    import regfile_spill_fill_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 spill_req,
    input  logic                 fill_req,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    regfile_spill_fill_if.master bus
);

    stateT                 stateQ, stateD;
    logic                  doneQ, doneD;
    logic                  errQ, errD;
    logic                  clearIdx, incrIdx, lastBeat, csumBeat;
    logic [BEAT_WIDTH-1:0] idx;
    logic [SEL_WIDTH-1:0]  selIdx;

    regfile_beat_counter uBeatCounter (
        .clk      (clk),
        .rst      (rst),
        .clear    (clearIdx),
        .incr     (incrIdx),
        .idx      (idx),
        .lastBeat (lastBeat)
    );

    assign selIdx = idx[SEL_WIDTH-1:0];

`ifdef RF_SPILL_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] xorQ, xorD;

    assign csumBeat = (idx == BEAT_WIDTH'(NUM_REGS));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xorQ <= '0;
        end else begin
            xorQ <= xorD;
        end
    end
`else
    assign csumBeat = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= StIdle;
            doneQ  <= 1'b0;
            errQ   <= 1'b0;
        end else begin
            stateQ <= stateD;
            doneQ  <= doneD;
            errQ   <= errD;
        end
    end

    always_comb begin
        stateD            = stateQ;
        doneD             = 1'b0;
        errD              = errQ;
        clearIdx          = 1'b0;
        incrIdx           = 1'b0;
        bus.rf_read_sel   = '0;
        bus.rf_write_en   = 1'b0;
        bus.rf_write_sel  = '0;
        bus.rf_write_data = '0;
        bus.out_valid     = 1'b0;
        bus.out_data      = '0;
        bus.out_last      = 1'b0;
        bus.in_ready      = 1'b0;
`ifdef RF_SPILL_CHECKSUM_EN
        xorD              = xorQ;
`endif

        case (stateQ)
            StIdle: begin
                if (spill_req || fill_req) begin
                    stateD   = spill_req ? StSpill : StFill;
                    errD     = 1'b0;
                    clearIdx = 1'b1;
`ifdef RF_SPILL_CHECKSUM_EN
                    xorD     = '0;
`endif
                end
            end

            StSpill: begin
                bus.out_valid   = 1'b1;
                bus.out_last    = lastBeat;
                bus.rf_read_sel = selIdx;
                bus.out_data    = bus.rf_read_data;
`ifdef RF_SPILL_CHECKSUM_EN
                if (csumBeat) begin
                    bus.rf_read_sel = '0;
                    bus.out_data    = xorQ;
                end else if (bus.out_ready) begin
                    xorD = xorQ ^ bus.rf_read_data;
                end
`endif
                if (bus.out_ready) begin
                    incrIdx = 1'b1;
                    if (lastBeat) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end
                end
            end

            StFill: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    incrIdx = 1'b1;
                    if (!csumBeat) begin
                        bus.rf_write_en   = 1'b1;
                        bus.rf_write_sel  = selIdx;
                        bus.rf_write_data = bus.in_data;
`ifdef RF_SPILL_CHECKSUM_EN
                        xorD              = xorQ ^ bus.in_data;
`endif
                    end
`ifdef RF_SPILL_CHECKSUM_EN
                    else if (bus.in_data != xorQ) begin
                        errD = 1'b1;
                    end
`endif
                    // A framing error still writes the offending beat, then stops.
                    if (bus.in_last != lastBeat) begin
                        errD   = 1'b1;
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end else if (lastBeat) begin
                        stateD = StIdle;
                        doneD  = 1'b1;
                    end
                end
            end

            default: stateD = StIdle;
        endcase
    end

    assign busy = (stateQ != StIdle);
    assign done = doneQ;
    assign err  = errQ;

endmodule

// File: tb/tb_regfile_spill_fill.sv
// tb_regfile_spill_fill
// Self-checking bench: a behavioural 8x16 register file sits on the slave side of the bus.
module tb_regfile_spill_fill;
    import regfile_spill_fill_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic spill_req = 1'b0;
    logic fill_req = 1'b0;
    logic busy, done, err;

    int total = 0;
    int bad = 0;

    logic [15:0] rf [8];
    logic [15:0] spillExp [BEAT_COUNT];

    regfile_spill_fill_if bus ();

    regfile_spill_fill dut (
        .clk       (clk),
        .rst       (rst),
        .spill_req (spill_req),
        .fill_req  (fill_req),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .bus       (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.rf_write_en) rf[bus.rf_write_sel] <= bus.rf_write_data;
    end
    assign bus.rf_read_data = rf[bus.rf_read_sel];

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [15:0] base);
        logic [15:0] x;
        x = '0;
        for (int i = 0; i < 8; i++) begin
            rf[i] <= base + 16'(i);
            spillExp[i] = base + 16'(i);
            x = x ^ (base + 16'(i));
        end
        if (BEAT_COUNT > 8) spillExp[BEAT_COUNT-1] = x;
        #1;
    endtask

    task automatic startReq(input logic s, input logic f);
        spill_req = s;
        fill_req  = f;
        tick();
        spill_req = 1'b0;
        fill_req  = 1'b0;
        check("req_busy", busy, 1'b1);
    endtask

    // Runs one spill with a repeating out_ready pattern; pat[0] applies first.
    task automatic spillRun(input string tag, input logic [3:0] pat);
        int k = 0;
        int c = 0;
        while (k < BEAT_COUNT && c < 64) begin
            bus.out_ready = pat[c % 4];
            #1;
            check({tag, "_valid"}, bus.out_valid, 1'b1);
            check({tag, "_data"}, bus.out_data, spillExp[k]);
            check({tag, "_last"}, bus.out_last, (k == BEAT_COUNT - 1));
            check({tag, "_nowrite"}, bus.rf_write_en, 1'b0);
            check({tag, "_inready"}, bus.in_ready, 1'b0);
            check({tag, "_done_early"}, done, 1'b0);
            if (bus.out_ready) k++;
            c++;
            tick();
        end
        bus.out_ready = 1'b0;
        #1;
        check({tag, "_done"}, done, 1'b1);
        check({tag, "_idle"}, busy, 1'b0);
        check({tag, "_outvalid_off"}, bus.out_valid, 1'b0);
        tick();
        check({tag, "_done_pulse"}, done, 1'b0);
    endtask

    // Drives nBeats fill beats; in_last on beat lastAt-1 (lastAt 0 = never).
    task automatic fillRun(input logic [15:0] base, input int lastAt, input int nBeats,
                           input logic [15:0] csum);
        for (int b = 0; b < nBeats; b++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = (b == 8) ? csum : base + 16'(b);
            bus.in_last  = (b == lastAt - 1);
            #1;
            check("fill_ready", bus.in_ready, 1'b1);
            check("fill_wen", bus.rf_write_en, (b < 8));
            if (b < 8) check("fill_wsel", bus.rf_write_sel, 32'(b));
            check("fill_outvalid", bus.out_valid, 1'b0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        #1;
        check("fill_done", done, 1'b1);
        check("fill_idle", busy, 1'b0);
        check("fill_inready_off", bus.in_ready, 1'b0);
    endtask

    typedef struct {
        logic [15:0] base;
        int          lastAt;
        logic        expErr;
        int          expWritten;
    } fillVecT;

    initial begin
        fillVecT vecs [4];
        vecs[0] = '{base: 16'hA0A0, lastAt: 8, expErr: 1'b0, expWritten: 8};
        vecs[1] = '{base: 16'h5500, lastAt: 5, expErr: 1'b1, expWritten: 5};
        vecs[2] = '{base: 16'h0F00, lastAt: 1, expErr: 1'b1, expWritten: 1};
        vecs[3] = '{base: 16'h7770, lastAt: 0, expErr: 1'b1, expWritten: 8};

        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        for (int i = 0; i < 8; i++) rf[i] = '0;

        // Reset values
        #12;
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_out_last", bus.out_last, 1'b0);
        check("rst_in_ready", bus.in_ready, 1'b0);
        check("rst_wen", bus.rf_write_en, 1'b0);
        check("rst_rsel", bus.rf_read_sel, 3'd0);
        check("rst_wsel", bus.rf_write_sel, 3'd0);
        check("rst_wdata", bus.rf_write_data, 16'h0000);
        rst = 1'b1;
        tick();

        // Spill, out_ready held high
        preload(16'h1000);
        startReq(1'b1, 1'b0);
        spillRun("spill_full", 4'b1111);

        // Spill with out_ready 1,0,0,1 repeating
        startReq(1'b1, 1'b0);
        spillRun("spill_stall", 4'b1001);

`ifndef RF_SPILL_CHECKSUM_EN
        // Fill vector table
        for (int v = 0; v < 4; v++) begin
            preload(16'h1000);
            startReq(1'b0, 1'b1);
            fillRun(vecs[v].base, vecs[v].lastAt,
                    (vecs[v].lastAt == 0) ? 8 : vecs[v].lastAt, 16'h0000);
            check("fill_err", err, vecs[v].expErr);
            tick();
            check("fill_err_sticky", err, vecs[v].expErr);
            for (int i = 0; i < 8; i++) begin
                check("fill_reg", rf[i],
                      (i < vecs[v].expWritten) ? vecs[v].base + 16'(i) : 16'h1000 + 16'(i));
            end
        end
`else
        // Checksum beat: XOR of 0x0001..0x0008 is 0x0008
        preload(16'h0001);
        check("csum_model", spillExp[8], 16'h0008);
        startReq(1'b1, 1'b0);
        spillRun("spill_csum", 4'b1111);
        // Fill with a wrong checksum still writes all eight registers
        preload(16'h1000);
        startReq(1'b0, 1'b1);
        fillRun(16'hA0A0, 9, 9, 16'h0000);
        check("csum_fill_err", err, 1'b1);
        for (int i = 0; i < 8; i++) check("csum_fill_reg", rf[i], 16'hA0A0 + 16'(i));
`endif

        // Both requests together: spill wins, nothing is written, err cleared
        preload(16'h2000);
        startReq(1'b1, 1'b1);
        check("both_err_clear", err, 1'b0);
        spillRun("spill_both", 4'b1111);
        for (int i = 0; i < 8; i++) check("both_reg", rf[i], 16'h2000 + 16'(i));

        // Reset during the 4th spill beat
        startReq(1'b1, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        tick();
        tick();
        #1;
        check("mid_beat4_data", bus.out_data, 16'h2003);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", busy, 1'b0);
        check("mid_rst_valid", bus.out_valid, 1'b0);
        check("mid_rst_last", bus.out_last, 1'b0);
        check("mid_rst_rsel", bus.rf_read_sel, 3'd0);
        check("mid_rst_done", done, 1'b0);
        tick();
        check("mid_rst_done2", done, 1'b0);
        rst = 1'b1;
        bus.out_ready = 1'b0;
        tick();
        check("post_rst_done", done, 1'b0);
        check("post_rst_busy", busy, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
